// File: rtl/sad_search_controller.sv
// Template-matching search sequencer: walks every vertical offset of a strip,
// drives ROM/RAM addresses and PE strobes, reports first or best SAD match.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   start, mode             : search request (IDLE only), 0=first 1=best match
//   fifo_ready              : image strip loaded (WAIT_FIFO only)
//   pe_match, pe_sad        : PE threshold flag and accumulated SAD
//   uart_done               : report transmitted (REPORT only)
//   ram_row, rom_addr       : image row / template addresses
//   pe_reset, pe_shift      : combinational PE strobes (SCAN only)
//   uart_send               : 0=OFF 1=MATCH 2=NOT_MATCH
//   result_row, result_sad  : reported offset and SAD
//   busy                    : high outside IDLE
module sad_search_controller #(
  parameter int TPL_COLS    = 40,
  parameter int TPL_ROWS    = 100,
  parameter int SEARCH_ROWS = 380,
  parameter int RAM_AW      = 9,
  parameter int ROM_AW      = 12,
  parameter int SAD_W       = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              fifo_ready,
  input  logic              mode,
  input  logic              pe_match,
  input  logic [SAD_W-1:0]  pe_sad,
  input  logic              uart_done,
  output logic [RAM_AW-1:0] ram_row,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              pe_reset,
  output logic              pe_shift,
  output logic [1:0]        uart_send,
  output logic [RAM_AW-1:0] result_row,
  output logic [SAD_W-1:0]  result_sad,
  output logic              busy
);

  localparam int COL_W = (TPL_COLS > 1) ? $clog2(TPL_COLS) : 1;

  localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(TPL_ROWS * TPL_COLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(TPL_COLS - 1);
  localparam logic [RAM_AW-1:0] LAST_OFF  = RAM_AW'(SEARCH_ROWS - 1);

  localparam logic [1:0] U_OFF   = 2'd0;
  localparam logic [1:0] U_MATCH = 2'd1;
  localparam logic [1:0] U_NOM   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIFO,
    SCAN,
    REPORT
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [RAM_AW-1:0] offset_q, offset_d;
  logic [COL_W-1:0]  tpl_col_q, tpl_col_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [RAM_AW-1:0] ram_row_q, ram_row_d;
  logic              best_valid_q, best_valid_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [RAM_AW-1:0] best_row_q, best_row_d;
  logic [RAM_AW-1:0] result_row_q, result_row_d;
  logic [SAD_W-1:0]  result_sad_q, result_sad_d;
  logic [1:0]        uart_send_q, uart_send_d;

  logic col_wrap;
  logic win_end;
  logic full_win;
  logic best_upd;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    offset_d     = offset_q;
    tpl_col_d    = tpl_col_q;
    rom_addr_d   = rom_addr_q;
    ram_row_d    = ram_row_q;
    best_valid_d = best_valid_q;
    best_sad_d   = best_sad_q;
    best_row_d   = best_row_q;
    result_row_d = result_row_q;
    result_sad_d = result_sad_q;
    uart_send_d  = uart_send_q;
    pe_shift     = 1'b0;
    pe_reset     = 1'b0;
    col_wrap     = (tpl_col_q == LAST_COL);
    win_end      = (rom_addr_q == LAST_ADDR) || !pe_match;
    full_win     = 1'b0;
    best_upd     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = WAIT_FIFO;
          mode_d       = mode;
          best_valid_d = 1'b0;
          best_sad_d   = '1;
          best_row_d   = '0;
          result_row_d = '0;
          result_sad_d = '0;
          offset_d     = '0;
          tpl_col_d    = '0;
          rom_addr_d   = '0;
          ram_row_d    = '0;
        end
      end

      WAIT_FIFO: begin
        offset_d   = '0;
        tpl_col_d  = '0;
        rom_addr_d = '0;
        ram_row_d  = '0;
        if (fifo_ready) begin
          state_d = SCAN;
        end
      end

      SCAN: begin
        pe_shift = col_wrap;
        pe_reset = win_end;
        if (win_end) begin
          // pe_match at window end separates a full window from an abort
          full_win = pe_match;
          best_upd = full_win && mode_q &&
                     (!best_valid_q || pe_sad < best_sad_q);
          if (best_upd) begin
            best_valid_d = 1'b1;
            best_sad_d   = pe_sad;
            best_row_d   = offset_q;
          end
          tpl_col_d  = '0;
          rom_addr_d = '0;
          if (full_win && !mode_q) begin
            state_d      = REPORT;
            uart_send_d  = U_MATCH;
            result_row_d = offset_q;
            result_sad_d = pe_sad;
            offset_d     = '0;
            ram_row_d    = '0;
          end else if (offset_q == LAST_OFF) begin
            state_d   = REPORT;
            offset_d  = '0;
            ram_row_d = '0;
            // include this cycle's window in the final best-match decision
            if (best_upd) begin
              uart_send_d  = U_MATCH;
              result_row_d = offset_q;
              result_sad_d = pe_sad;
            end else if (best_valid_q) begin
              uart_send_d  = U_MATCH;
              result_row_d = best_row_q;
              result_sad_d = best_sad_q;
            end else begin
              uart_send_d = U_NOM;
            end
          end else begin
            offset_d  = offset_q + RAM_AW'(1);
            ram_row_d = offset_q + RAM_AW'(1);
          end
        end else begin
          rom_addr_d = rom_addr_q + ROM_AW'(1);
          if (col_wrap) begin
            tpl_col_d = '0;
            ram_row_d = ram_row_q + RAM_AW'(1);
          end else begin
            tpl_col_d = tpl_col_q + COL_W'(1);
          end
        end
      end

      REPORT: begin
        if (uart_done) begin
          state_d     = IDLE;
          uart_send_d = U_OFF;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      offset_q     <= '0;
      tpl_col_q    <= '0;
      rom_addr_q   <= '0;
      ram_row_q    <= '0;
      best_valid_q <= 1'b0;
      best_sad_q   <= '1;
      best_row_q   <= '0;
      result_row_q <= '0;
      result_sad_q <= '0;
      uart_send_q  <= U_OFF;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      offset_q     <= offset_d;
      tpl_col_q    <= tpl_col_d;
      rom_addr_q   <= rom_addr_d;
      ram_row_q    <= ram_row_d;
      best_valid_q <= best_valid_d;
      best_sad_q   <= best_sad_d;
      best_row_q   <= best_row_d;
      result_row_q <= result_row_d;
      result_sad_q <= result_sad_d;
      uart_send_q  <= uart_send_d;
    end
  end

  assign ram_row    = ram_row_q;
  assign rom_addr   = rom_addr_q;
  assign uart_send  = uart_send_q;
  assign result_row = result_row_q;
  assign result_sad = result_sad_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sad_search_controller.sv
// Randomised and directed bench for sad_search_controller with a
// small behavioural model of the search (first/best match) per run.
module tb_sad_search_controller;

  localparam int C = 4;
  localparam int R = 3;
  localparam int S = 6;
  localparam int N = C * R;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        fifo_ready;
  logic        mode;
  logic        pe_match;
  logic [19:0] pe_sad;
  logic        uart_done;
  logic [8:0]  ram_row;
  logic [11:0] rom_addr;
  logic        pe_reset;
  logic        pe_shift;
  logic [1:0]  uart_send;
  logic [8:0]  result_row;
  logic [19:0] result_sad;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ab[S];
  int sd[S];

  sad_search_controller #(
    .TPL_COLS(C), .TPL_ROWS(R), .SEARCH_ROWS(S),
    .RAM_AW(9), .ROM_AW(12), .SAD_W(20)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .fifo_ready(fifo_ready), .mode(mode),
    .pe_match(pe_match), .pe_sad(pe_sad),
    .uart_done(uart_done), .ram_row(ram_row),
    .rom_addr(rom_addr), .pe_reset(pe_reset),
    .pe_shift(pe_shift), .uart_send(uart_send),
    .result_row(result_row), .result_sad(result_sad),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({busy, uart_send, rom_addr, ram_row,
         result_row, result_sad, pe_shift, pe_reset} !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b send=%0d rom=%0d ram=%0d",
               busy, uart_send, rom_addr, ram_row);
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_start(input bit m, input int wt);
    @(negedge clock);
    start = 1'b1;
    mode  = m;
    @(negedge clock);
    mode = ~m;
    #1;
    checks++;
    if ({busy, uart_send, rom_addr, ram_row} !== {1'b1, 23'd0}) begin
      errors++;
      $display("FAIL start_accept busy=%b send=%0d rom=%0d",
               busy, uart_send, rom_addr);
    end
    for (int i = 0; i < wt; i++) begin
      start = $urandom_range(0, 1);
      @(negedge clock);
    end
    start = 1'b0;
    fifo_ready = 1'b1;
    @(negedge clock);
    fifo_ready = 1'b0;
  endtask

  task automatic scan_and_report(input bit m);
    int exp_end, brow, bsad, len;
    bit bv;
    logic [1:0]  exp_send;
    logic [8:0]  exp_row;
    logic [19:0] exp_sad;
    logic [25:0] exp_v;
    exp_end = S - 1;
    bv = 0; brow = 0; bsad = 0;
    for (int o = 0; o < S; o++) begin
      if (ab[o] < 0) begin
        if (!m) begin
          bv = 1; brow = o; bsad = sd[o]; exp_end = o;
          break;
        end
        if (!bv || sd[o] < bsad) begin
          bv = 1; brow = o; bsad = sd[o];
        end
      end
    end
    exp_send = bv ? 2'd1 : 2'd2;
    exp_row  = bv ? 9'(brow) : 9'd0;
    exp_sad  = bv ? 20'(bsad) : 20'd0;

    for (int o = 0; o <= exp_end; o++) begin
      len = (ab[o] < 0) ? N : ab[o] + 1;
      for (int c = 0; c < len; c++) begin
        pe_match = (c != ab[o]);
        pe_sad   = 20'(sd[o]);
        start    = $urandom_range(0, 1);
        mode     = $urandom_range(0, 1);
        fifo_ready = $urandom_range(0, 1);
        uart_done  = $urandom_range(0, 1);
        #1;
        exp_v = {12'(c), 9'(o + c / C), (c % C) == C - 1,
                 c == len - 1, 2'd0, 1'b1};
        checks++;
        if ({rom_addr, ram_row, pe_shift, pe_reset,
             uart_send, busy} !== exp_v) begin
          errors++;
          $display("FAIL scan off=%0d c=%0d got %h exp %h",
                   o, c, {rom_addr, ram_row, pe_shift, pe_reset,
                          uart_send, busy}, exp_v);
        end
        @(negedge clock);
      end
    end

    start = 1'b0;
    fifo_ready = 1'b0;
    uart_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pe_match = $urandom_range(0, 1);
      #1;
      checks++;
      if ({uart_send, result_row, result_sad, busy,
           pe_shift, pe_reset} !==
          {exp_send, exp_row, exp_sad, 3'b100}) begin
        errors++;
        $display("FAIL report i=%0d send=%0d/%0d row=%0d/%0d sad=%0d/%0d",
                 i, uart_send, exp_send, result_row, exp_row,
                 result_sad, exp_sad);
      end
      @(negedge clock);
    end
    uart_done = 1'b1;
    @(negedge clock);
    uart_done = 1'b0;
    #1;
    checks++;
    if ({uart_send, busy, result_row, result_sad} !==
        {3'b000, exp_row, exp_sad}) begin
      errors++;
      $display("FAIL report_done send=%0d busy=%b row=%0d exp_row=%0d",
               uart_send, busy, result_row, exp_row);
    end
  endtask

  task automatic run(input bit m);
    do_start(m, $urandom_range(0, 3));
    scan_and_report(m);
  endtask

  task automatic test_first_match();
    ab = '{2, 2, -1, 0, 0, 0};
    sd = '{9, 9, 37, 1, 1, 1};
    run(1'b0);
  endtask

  task automatic test_best_match();
    ab = '{1, -1, 1, -1, 1, -1};
    sd = '{3, 50, 3, 20, 3, 20};
    run(1'b1);
  endtask

  task automatic test_no_match();
    ab = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < S; i++) sd[i] = $urandom_range(0, 9);
    run($urandom_range(0, 1));
  endtask

  task automatic test_ram_row();
    ab = '{0, 0, 0, 0, -1, 0};
    sd = '{5, 5, 5, 5, 77, 5};
    run(1'b0);
  endtask

  task automatic test_mid_reset();
    do_start(1'b0, 1);
    for (int o = 0; o < 3; o++) begin
      pe_match = 1'b0;
      @(negedge clock);
    end
    pe_match = 1'b1;
    for (int c = 0; c < C; c++) @(negedge clock);
    #1;
    checks++;
    if ({rom_addr, ram_row} !== {12'd4, 9'd4}) begin
      errors++;
      $display("FAIL mid_pos rom=%0d ram=%0d exp 4 4",
               rom_addr, ram_row);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, uart_send, rom_addr, ram_row,
         result_row, result_sad, pe_shift, pe_reset} !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b send=%0d rom=%0d ram=%0d",
               busy, uart_send, rom_addr, ram_row);
    end
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({busy, uart_send} !== 3'b000) begin
      errors++;
      $display("FAIL reset_quiet busy=%b send=%0d", busy, uart_send);
    end
    ab = '{-1, 0, 0, 0, 0, 0};
    sd = '{12, 0, 0, 0, 0, 0};
    run(1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < S; i++) begin
        ab[i] = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, N - 1);
        sd[i] = $urandom_range(0, 7);
      end
      run($urandom_range(0, 1));
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    fifo_ready = 1'b0;
    mode = 1'b0;
    pe_match = 1'b1;
    pe_sad = '0;
    uart_done = 1'b0;
    test_reset();
    test_first_match();
    test_best_match();
    test_no_match();
    test_ram_row();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sad_search_controller.md
Name: sad_search_controller

Overview:
- Parametrised successor to the SAD processor control unit; sequences a template-matching search over a vertical strip of image rows.
- Drives template ROM and image RAM addresses, plus shift and reset strobes to the SAD processing element (PE).
- Supports first-match and best-match (minimum SAD) modes and reports the result row and SAD to the UART sender.
- Sits between the UART receive/FIFO front end and the PE array.

Parameters:
- TPL_COLS, 40, template columns; row-wrap point of the column counter.
- TPL_ROWS, 100, template rows.
- SEARCH_ROWS, 380, number of vertical offsets tried (0..SEARCH_ROWS-1).
- RAM_AW, 9, image RAM row address width.
- ROM_AW, 12, template ROM address width; must hold TPL_ROWS*TPL_COLS-1.
- SAD_W, 20, SAD value width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  search request; sampled only in IDLE
- fifo_ready  in  1  image strip loaded
- mode  in  1  0 = first match, 1 = best match; latched on the start acceptance
- pe_match  in  1  PE running SAD at or below threshold
- pe_sad  in  SAD_W  PE accumulated SAD, valid on window completion
- uart_done  in  1  UART report transmitted
- ram_row  out  RAM_AW  image RAM row address
- rom_addr  out  ROM_AW  template ROM address
- pe_reset  out  1  clear PE accumulator (combinational)
- pe_shift  out  1  shift PE image row (combinational)
- uart_send  out  2  0 = OFF, 1 = MATCH, 2 = NOT_MATCH (registered)
- result_row  out  RAM_AW  winning offset
- result_sad  out  SAD_W  winning SAD
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all registered outputs 0; state IDLE; best_valid 0; best_sad all-ones.
- State IDLE:
  - start=1 → WAIT_FIFO on the next edge.
  - Latch mode; clear best_valid, best_sad, result_row and result_sad.
- State WAIT_FIFO: fifo_ready=1 → SCAN; offset, tpl_row, tpl_col, rom_addr and ram_row all 0.
- SCAN, once per cycle:
  - tpl_col increments and wraps at TPL_COLS-1.
  - On wrap, tpl_row and ram_row increment.
  - pe_shift = 1 exactly in cycles where tpl_col == TPL_COLS-1.
  - rom_addr = tpl_row*TPL_COLS + tpl_col, maintained as an incrementing counter (no multiplier).
  - ram_row = offset + tpl_row.
- Window end (win_end) occurs when rom_addr == TPL_ROWS*TPL_COLS-1 or pe_match == 0 (early abort):
  - pe_reset = 1 in that same cycle.
  - Next cycle: tpl_row/tpl_col/rom_addr = 0, offset += 1, ram_row = new offset.
- Full window: a win_end with pe_match == 1; pe_sad is sampled in that cycle.
  - mode 0: latch result_row = offset and result_sad = pe_sad → REPORT with uart_send = MATCH.
  - mode 1: if !best_valid or pe_sad < best_sad (strict), record offset and SAD and set best_valid. Ties keep the earlier offset.
- Last offset: win_end with offset == SEARCH_ROWS-1 (and no mode-0 match) → REPORT.
  - uart_send = MATCH if best_valid, else NOT_MATCH.
  - When a best-mode match is reported, result_row and result_sad hold the best values.
- Abort/full tie: an abort and a full-window end in the same cycle cannot coexist; pe_match selects which one applies.
- REPORT:
  - uart_send is held until uart_done = 1, then goes to IDLE with uart_send = 0.
  - result_row and result_sad hold until the next start.
- Full-window latency: TPL_ROWS*TPL_COLS cycles per offset. Aborted window: ends in the abort cycle.
- Outside SCAN: pe_shift = 0 and pe_reset = 0.
- Ignored inputs:
  - start while busy is ignored.
  - fifo_ready outside WAIT_FIFO is ignored.
  - uart_done outside REPORT is ignored.
- Reset asserted in any state: IDLE next edge, all outputs to reset values, and no UART report is issued.
- Offset counter never exceeds SEARCH_ROWS-1; ram_row never exceeds SEARCH_ROWS+TPL_ROWS-2.

Test Plan:
- Bench parameters for all scenarios: TPL_COLS=4, TPL_ROWS=3, SEARCH_ROWS=6.
- Mode 0, PE aborts offsets 0-1 at cycle 2, offset 2 is a full window with sad=37:
  - → uart_send=1, result_row=2, result_sad=37.
  - pe_shift pulses at tpl_col=3.
  - rom_addr runs 0..11 in offset 2.
- Mode 1, full windows at offsets 1 (sad 50), 3 (sad 20) and 5 (sad 20), others abort:
  - → result_row=3, result_sad=20, uart_send=1 only after offset 5 completes.
- Either mode, pe_match held 0:
  - → each offset lasts 1 cycle with pe_reset=1.
  - → uart_send=2 after offset 5; result_row=0.
- Reset asserted mid-SCAN at offset 3, tpl_row 1:
  - → next cycle IDLE, busy=0, all outputs 0.
  - A new start runs cleanly from offset 0.
- Timing and input-ignore checks:
  - uart_done held low for 10 cycles in REPORT → uart_send stays constant.
  - uart_done=1 → IDLE, uart_send=0.
  - start pulsed while busy → no effect.
- ram_row check for a full window at offset 4: ram_row = 4,4,4,4,5,5,5,5,6,6,6,6 across rom_addr 0..11.
